mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Parametrised multicycle MIPS control FSM, successor to the fixed-latency controller.
//  Sits beside the multicycle datapath, sequencing fetch/decode/execute/memory/writeback.
//  Adds: variable-latency memory handshake, wider ALUOp (ORI/SLTI support), retire pulse/counter.
// PARAMETERS
//  OP_W     6   opcode field width
//  ALUOP_W  3   ALUOp width (>=3)
//  CNT_W    16  retired-instruction counter width
// PORTS
//  Clk         in   1        clock, all state on rising edge
//  Rst_n       in   1        asynchronous, active-low reset
//  OpCode      in   OP_W     IR[31:26]
//  Zero        in   1        ALU zero flag
//  MemReady    in   1        memory completes current access this cycle
//  IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,Jal  out 1  datapath controls
//  ALUSrcB     out  2        00 B, 01 const 4, 10 SignExt, 11 SignExt<<2
//  PCSource    out  2        00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
//  ALUOp       out  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//  PCSel       out  1        PC load = PCWrite | (CondEq & Zero) | (CondNe & ~Zero)
//  InstrDone   out  1        1-cycle pulse on final cycle of every instruction
//  InstrCount  out  CNT_W    retired instructions, wraps 2^CNT_W-1 -> 0
//  Trap        out  1        illegal-opcode trap (see CONFIGURATION)
// BEHAVIOUR
//  Reset: Rst_n low -> state=FETCH, InstrCount=0, every output forced 0 while low.
//  Outputs combinational from state (plus MemReady in FETCH/MEMRD/MEMWR); default 0.
//  States / transitions:
//   FETCH: MemRead, ALUSrcB=01; IRWrite=PCWrite=MemReady; hold until MemReady -> DECODE.
//   DECODE: ALUSrcB=11; lw/sw->MEMADR, R(000000)->EXEC, beq->BEQ, bne->BNE, j->J,
//     jal->JAL, addi/andi/ori/slti (001000/001100/001101/001010)->IMMEXEC, else illegal.
//   MEMADR: ALUSrcA=1, ALUSrcB=10; lw->MEMRD, sw->MEMWR.
//   MEMRD: MemRead, IorD; hold until MemReady -> MEMWB.
//   MEMWB: RegWrite, MemtoReg, RegDst=0; done -> FETCH.
//   MEMWR: MemWrite, IorD; hold until MemReady; done on ready cycle -> FETCH.
//   EXEC: ALUSrcA=1, ALUOp=010 -> RTEND: RegDst=1, RegWrite; done.
//   BEQ/BNE: ALUSrcA=1, ALUOp=001, PCSource=01, CondEq/CondNe; done.
//   J: PCWrite, PCSource=10; done. JAL: J plus Jal, RegWrite; done.
//   IMMEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode (000/011/100/101), registered
//     into op latch so IMMEND is opcode-independent -> IMMEND: RegWrite, RegDst=0; done.
//  "done" = InstrDone=1 that cycle, InstrCount+1 at the clock edge; next state FETCH.
//  MemReady ignored outside FETCH/MEMRD/MEMWR; MemReady held high gives original latency
//   (lw 5, sw 4, R/imm 4, branch/jump 3 cycles).
//  Rst_n asserted mid-instruction: immediate abort, no InstrDone, no partial writes.
//  OpCode must be stable from FETCH-complete until instruction done (IR-held).
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP state: Trap=1, PCWrite,
//   PCSource=11; counts as done; -> FETCH.
//  Not defined: illegal opcode -> FETCH directly, no done, Trap tied 0, PCSource 11 unused.
// STRUCTURE
//  Package mc_ctrl_pkg: state enum (4-bit), opcode constants, ALUOp encodings,
//   ALUSrcB/PCSource encodings.
//  Sub-module mc_retire_cnt (CNT_W counter, async active-low clear, inc on InstrDone).
//  FSM register, next-state logic, output decode kept in this module.
// TESTING
//  lw, MemReady=1 always -> 5 cycles, InstrDone once, InstrCount 0->1, RegWrite+MemtoReg in cycle 5.
//  lw with MemReady low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles, IRWrite/PCWrite only on ready.
//  beq Zero=1 then bne Zero=1 -> PCSel=1 in first BEQ cycle, PCSel=0 in BNE cycle.
//  ori (001101) -> ALUOp=100 in IMMEXEC, RegWrite=1 RegDst=0 in IMMEND; slti -> ALUOp=101.
//  OpCode 111111: with MC_ILLEGAL_TRAP_EN Trap=1, PCSource=11, count+1; without, FETCH, count unchanged.
//  Rst_n low during MEMWR with MemReady=0 -> MemWrite=0 immediately, FETCH after release, count=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RTEND   = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_J       = 4'd10,
      S_JAL     = 4'd11,
      S_IMMEXEC = 4'd12,
      S_IMMEND  = 4'd13,
      S_TRAP    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_TRAP   = 2'b11;

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter: increments once per InstrDone pulse, wraps naturally.
module mc_retire_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // count retired instructions; cleared asynchronously by reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with variable-latency memory handshake,
// immediate ALU ops, and retire pulse/counter.
// Optional: define MC_ILLEGAL_TRAP_EN to route illegal opcodes through a TRAP
// state (Trap=1, PC <- trap vector, counted as retired). Without it, illegal
// opcodes return straight to FETCH and are not counted.
//
// state    | meaning
// FETCH    | read instruction; IR/PC written on MemReady
// DECODE   | register read, branch target precompute, dispatch on opcode
// MEMADR   | compute load/store address
// MEMRD    | load access, wait for MemReady
// MEMWB    | write load data to rt (done)
// MEMWR    | store access, done on MemReady
// EXEC     | R-type ALU operation
// RTEND    | write ALU result to rd (done)
// BEQ/BNE  | compare and conditionally take branch (done)
// J/JAL    | jump, JAL also links (done)
// IMMEXEC  | immediate ALU op using latched ALUOp
// IMMEND   | write ALU result to rt (done)
// TRAP     | illegal opcode, PC <- trap vector (done, trap build only)
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [OP_W-1:0]    OpCode,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic               Jal,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               PCSel,
   output logic               InstrDone,
   output logic [CNT_W-1:0]   InstrCount,
   output logic               Trap
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_imm_aluop;
   logic [2:0] w_imm_aluop;

   logic w_op_rtype, w_op_lw, w_op_sw, w_op_beq, w_op_bne, w_op_j, w_op_jal;
   logic w_op_imm;

   logic       w_iord, w_mem_read, w_mem_write, w_memtoreg, w_ir_write;
   logic       w_reg_dst, w_reg_write, w_alu_src_a, w_jal;
   logic       w_pc_write, w_cond_eq, w_cond_ne, w_done;
   logic [1:0] w_alu_src_b, w_pc_source;
   logic [2:0] w_alu_op;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       w_trap;
`endif

   assign w_op_rtype = (OpCode == OP_W'(OP_RTYPE));
   assign w_op_lw    = (OpCode == OP_W'(OP_LW));
   assign w_op_sw    = (OpCode == OP_W'(OP_SW));
   assign w_op_beq   = (OpCode == OP_W'(OP_BEQ));
   assign w_op_bne   = (OpCode == OP_W'(OP_BNE));
   assign w_op_j     = (OpCode == OP_W'(OP_J));
   assign w_op_jal   = (OpCode == OP_W'(OP_JAL));
   assign w_op_imm   = (OpCode == OP_W'(OP_ADDI)) | (OpCode == OP_W'(OP_ANDI)) |
                       (OpCode == OP_W'(OP_ORI))  | (OpCode == OP_W'(OP_SLTI));

   // select the ALU operation for an immediate-class opcode
   always_comb begin
      w_imm_aluop = ALU_ADD;
      if (OpCode == OP_W'(OP_ANDI)) begin
         w_imm_aluop = ALU_AND;
      end else if (OpCode == OP_W'(OP_ORI)) begin
         w_imm_aluop = ALU_OR;
      end else if (OpCode == OP_W'(OP_SLTI)) begin
         w_imm_aluop = ALU_SLT;
      end
   end

   // state register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // latch immediate ALUOp at dispatch so IMMEXEC/IMMEND no longer depend on OpCode decode
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_imm_aluop <= ALU_ADD;
      end else if (r_state == S_DECODE) begin
         r_imm_aluop <= w_imm_aluop;
      end
   end

   // next-state and raw control decode
   always_comb begin
      w_next      = r_state;
      w_iord      = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_memtoreg  = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_dst   = 1'b0;
      w_reg_write = 1'b0;
      w_alu_src_a = 1'b0;
      w_jal       = 1'b0;
      w_pc_write  = 1'b0;
      w_cond_eq   = 1'b0;
      w_cond_ne   = 1'b0;
      w_done      = 1'b0;
      w_alu_src_b = SRCB_B;
      w_pc_source = PCS_ALU;
      w_alu_op    = ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
      w_trap      = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_ir_write  = MemReady;
            w_pc_write  = MemReady;
            if (MemReady) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_b = SRCB_SEXT_SH;
            if (w_op_lw || w_op_sw)   w_next = S_MEMADR;
            else if (w_op_rtype)      w_next = S_EXEC;
            else if (w_op_beq)        w_next = S_BEQ;
            else if (w_op_bne)        w_next = S_BNE;
            else if (w_op_j)          w_next = S_J;
            else if (w_op_jal)        w_next = S_JAL;
            else if (w_op_imm)        w_next = S_IMMEXEC;
`ifdef MC_ILLEGAL_TRAP_EN
            else                      w_next = S_TRAP;
`else
            else                      w_next = S_FETCH;
`endif
         end
         S_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_SEXT;
            w_next      = w_op_sw ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            if (MemReady) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_reg_write = 1'b1;
            w_memtoreg  = 1'b1;
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            if (MemReady) begin
               w_done = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_FUNCT;
            w_next      = S_RTEND;
         end
         S_RTEND: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
         S_BEQ, S_BNE: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_SUB;
            w_pc_source = PCS_ALUOUT;
            w_cond_eq   = (r_state == S_BEQ);
            w_cond_ne   = (r_state == S_BNE);
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
         S_J, S_JAL: begin
            w_pc_write  = 1'b1;
            w_pc_source = PCS_JUMP;
            w_jal       = (r_state == S_JAL);
            w_reg_write = (r_state == S_JAL);
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
         S_IMMEXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_SEXT;
            w_alu_op    = r_imm_aluop;
            w_next      = S_IMMEND;
         end
         S_IMMEND: begin
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            w_trap      = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_source = PCS_TRAP;
            w_done      = 1'b1;
            w_next      = S_FETCH;
         end
`endif
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // every output is forced low while reset is held, so an abort leaves no partial write
   assign IorD      = Rst_n & w_iord;
   assign MemRead   = Rst_n & w_mem_read;
   assign MemWrite  = Rst_n & w_mem_write;
   assign MemtoReg  = Rst_n & w_memtoreg;
   assign IRWrite   = Rst_n & w_ir_write;
   assign RegDst    = Rst_n & w_reg_dst;
   assign RegWrite  = Rst_n & w_reg_write;
   assign ALUSrcA   = Rst_n & w_alu_src_a;
   assign Jal       = Rst_n & w_jal;
   assign ALUSrcB   = w_alu_src_b & {2{Rst_n}};
   assign PCSource  = w_pc_source & {2{Rst_n}};
   assign ALUOp     = ALUOP_W'(w_alu_op & {3{Rst_n}});
   assign PCSel     = Rst_n & (w_pc_write | (w_cond_eq & Zero) | (w_cond_ne & ~Zero));
   assign InstrDone = Rst_n & w_done;
`ifdef MC_ILLEGAL_TRAP_EN
   assign Trap      = Rst_n & w_trap;
`else
   assign Trap      = 1'b0;
`endif

   mc_retire_cnt #(
      .CNT_W (CNT_W)
   ) u_retire_cnt (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_inc   (InstrDone),
      .o_count (InstrCount)
   );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expectations queued per instruction,
// popped and compared as the instruction runs.
module tb_mc_ctrl_fsm;

   localparam int OP_W    = 6;
   localparam int ALUOP_W = 3;
   localparam int CNT_W   = 16;

   localparam int SIG_MEMREAD  = 0;
   localparam int SIG_IRWRITE  = 1;
   localparam int SIG_PCSEL    = 2;
   localparam int SIG_REGWRITE = 3;
   localparam int SIG_MEMTOREG = 4;
   localparam int SIG_REGDST   = 5;
   localparam int SIG_ALUOP    = 6;
   localparam int SIG_PCSOURCE = 7;
   localparam int SIG_TRAP     = 8;
   localparam int SIG_MEMWRITE = 9;
   localparam int SIG_IORD     = 10;
   localparam int SIG_JAL      = 11;
   localparam int SIG_DONE     = 12;
   localparam int SIG_ALUSRCB  = 13;

   logic               Clk;
   logic               Rst_n;
   logic [OP_W-1:0]    OpCode;
   logic               Zero;
   logic               MemReady;
   logic               IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite;
   logic               ALUSrcA, Jal, PCSel, InstrDone, Trap;
   logic [1:0]         ALUSrcB, PCSource;
   logic [ALUOP_W-1:0] ALUOp;
   logic [CNT_W-1:0]   InstrCount;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt  = 0;

   mc_ctrl_fsm #(
      .OP_W    (OP_W),
      .ALUOP_W (ALUOP_W),
      .CNT_W   (CNT_W)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .OpCode     (OpCode),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .Jal        (Jal),
      .ALUSrcB    (ALUSrcB),
      .PCSource   (PCSource),
      .ALUOp      (ALUOp),
      .PCSel      (PCSel),
      .InstrDone  (InstrDone),
      .InstrCount (InstrCount),
      .Trap       (Trap)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [7:0] sig_val(input int s);
      case (s)
         SIG_MEMREAD:  return 8'(MemRead);
         SIG_IRWRITE:  return 8'(IRWrite);
         SIG_PCSEL:    return 8'(PCSel);
         SIG_REGWRITE: return 8'(RegWrite);
         SIG_MEMTOREG: return 8'(MemtoReg);
         SIG_REGDST:   return 8'(RegDst);
         SIG_ALUOP:    return 8'(ALUOp);
         SIG_PCSOURCE: return 8'(PCSource);
         SIG_TRAP:     return 8'(Trap);
         SIG_MEMWRITE: return 8'(MemWrite);
         SIG_IORD:     return 8'(IorD);
         SIG_JAL:      return 8'(Jal);
         SIG_DONE:     return 8'(InstrDone);
         SIG_ALUSRCB:  return 8'(ALUSrcB);
         default:      return 8'hxx;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_at(input int cyc, input int sig, input logic [7:0] val, input string tag);
      exp_t e;
      e.cyc = cyc;
      e.sig = sig;
      e.val = val;
      e.tag = tag;
      sbq.push_back(e);
   endtask

   // Runs one instruction for exactly n_cyc cycles. MemReady is low for the first fw
   // cycles (FETCH) and for mw cycles starting at the first memory-access cycle.
   task automatic run_instr(input string tag, input logic [5:0] op, input int fw,
                            input int mw, input logic z, input int n_cyc, input bit exp_done);
      int   dones;
      int   done_cyc;
      exp_t e;
      dones    = 0;
      done_cyc = -1;
      OpCode   = op;
      Zero     = z;
      for (int c = 0; c < n_cyc; c++) begin
         @(negedge Clk);
         MemReady = !((c < fw) || ((c >= fw + 3) && (c < fw + 3 + mw)));
         #1;
         while (sbq.size() > 0 && sbq[0].cyc == c) begin
            e = sbq.pop_front();
            chk($sformatf("%s_c%0d", e.tag, c), 32'(sig_val(e.sig)), 32'(e.val));
         end
         if (InstrDone === 1'b1) begin
            dones++;
            done_cyc = c;
         end
         @(posedge Clk);
      end
      #1;
      sbq.delete();
      if (exp_done) exp_cnt++;
      chk({tag, "_ndone"}, 32'(dones), exp_done ? 32'd1 : 32'd0);
      chk({tag, "_donecyc"}, 32'(done_cyc), exp_done ? 32'(n_cyc - 1) : 32'hffff_ffff);
      chk({tag, "_count"}, 32'(InstrCount), 32'(exp_cnt));
   endtask

   initial begin
      Rst_n    = 1'b0;
      OpCode   = 6'b100011;
      Zero     = 1'b0;
      MemReady = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_memread", 32'(MemRead), 32'd0);
      chk("rst_irwrite", 32'(IRWrite), 32'd0);
      chk("rst_alusrcb", 32'(ALUSrcB), 32'd0);
      chk("rst_pcsel", 32'(PCSel), 32'd0);
      chk("rst_count", 32'(InstrCount), 32'd0);
      MemReady = 1'b0;
      Rst_n    = 1'b1;

      // lw, zero-wait memory
      expect_at(0, SIG_MEMREAD, 8'd1, "lw_memread");
      expect_at(0, SIG_IRWRITE, 8'd1, "lw_irwrite");
      expect_at(0, SIG_ALUSRCB, 8'd1, "lw_srcb_fetch");
      expect_at(1, SIG_ALUSRCB, 8'd3, "lw_srcb_decode");
      expect_at(3, SIG_IORD, 8'd1, "lw_iord");
      expect_at(4, SIG_REGWRITE, 8'd1, "lw_regwrite");
      expect_at(4, SIG_MEMTOREG, 8'd1, "lw_memtoreg");
      expect_at(4, SIG_REGDST, 8'd0, "lw_regdst");
      run_instr("lw", 6'b100011, 0, 0, 1'b0, 5, 1'b1);

      // lw, 3 wait cycles in FETCH and 2 in MEMRD
      expect_at(0, SIG_IRWRITE, 8'd0, "lww_irwrite");
      expect_at(1, SIG_PCSEL, 8'd0, "lww_pcsel");
      expect_at(2, SIG_IRWRITE, 8'd0, "lww_irwrite");
      expect_at(3, SIG_IRWRITE, 8'd1, "lww_irwrite");
      expect_at(3, SIG_PCSEL, 8'd1, "lww_pcsel");
      expect_at(6, SIG_MEMREAD, 8'd1, "lww_memread");
      expect_at(8, SIG_MEMREAD, 8'd1, "lww_memread");
      expect_at(9, SIG_MEMTOREG, 8'd1, "lww_memtoreg");
      run_instr("lw_wait", 6'b100011, 3, 2, 1'b0, 10, 1'b1);

      // beq taken, bne not taken (Zero=1 for both)
      expect_at(2, SIG_PCSEL, 8'd1, "beq_pcsel");
      expect_at(2, SIG_ALUOP, 8'd1, "beq_aluop");
      expect_at(2, SIG_PCSOURCE, 8'd1, "beq_pcsource");
      run_instr("beq", 6'b000100, 0, 0, 1'b1, 3, 1'b1);
      expect_at(2, SIG_PCSEL, 8'd0, "bne_pcsel");
      run_instr("bne_z1", 6'b000101, 0, 0, 1'b1, 3, 1'b1);
      expect_at(2, SIG_PCSEL, 8'd1, "bne_pcsel");
      run_instr("bne_z0", 6'b000101, 0, 0, 1'b0, 3, 1'b1);

      // immediates
      expect_at(2, SIG_ALUOP, 8'd4, "ori_aluop");
      expect_at(2, SIG_ALUSRCB, 8'd2, "ori_srcb");
      expect_at(3, SIG_REGWRITE, 8'd1, "ori_regwrite");
      expect_at(3, SIG_REGDST, 8'd0, "ori_regdst");
      run_instr("ori", 6'b001101, 0, 0, 1'b0, 4, 1'b1);
      expect_at(2, SIG_ALUOP, 8'd5, "slti_aluop");
      run_instr("slti", 6'b001010, 0, 0, 1'b0, 4, 1'b1);
      expect_at(2, SIG_ALUOP, 8'd3, "andi_aluop");
      run_instr("andi", 6'b001100, 0, 0, 1'b0, 4, 1'b1);

      // R-type
      expect_at(2, SIG_ALUOP, 8'd2, "r_aluop");
      expect_at(3, SIG_REGDST, 8'd1, "r_regdst");
      expect_at(3, SIG_REGWRITE, 8'd1, "r_regwrite");
      run_instr("rtype", 6'b000000, 0, 0, 1'b0, 4, 1'b1);

      // sw with one wait cycle in MEMWR
      expect_at(3, SIG_MEMWRITE, 8'd1, "sw_memwrite");
      expect_at(3, SIG_DONE, 8'd0, "sw_done");
      expect_at(4, SIG_MEMWRITE, 8'd1, "sw_memwrite");
      expect_at(4, SIG_IORD, 8'd1, "sw_iord");
      run_instr("sw", 6'b101011, 0, 1, 1'b0, 5, 1'b1);

      // jumps
      expect_at(2, SIG_PCSOURCE, 8'd2, "j_pcsource");
      expect_at(2, SIG_PCSEL, 8'd1, "j_pcsel");
      expect_at(2, SIG_JAL, 8'd0, "j_jal");
      run_instr("j", 6'b000010, 0, 0, 1'b0, 3, 1'b1);
      expect_at(2, SIG_JAL, 8'd1, "jal_jal");
      expect_at(2, SIG_REGWRITE, 8'd1, "jal_regwrite");
      run_instr("jal", 6'b000011, 0, 0, 1'b0, 3, 1'b1);

      // illegal opcode
`ifdef MC_ILLEGAL_TRAP_EN
      expect_at(2, SIG_TRAP, 8'd1, "ill_trap");
      expect_at(2, SIG_PCSOURCE, 8'd3, "ill_pcsource");
      expect_at(2, SIG_PCSEL, 8'd1, "ill_pcsel");
      run_instr("illegal", 6'b111111, 0, 0, 1'b0, 3, 1'b1);
`else
      expect_at(1, SIG_TRAP, 8'd0, "ill_trap");
      run_instr("illegal", 6'b111111, 0, 0, 1'b0, 2, 1'b0);
`endif
      // following instruction must start in FETCH
      expect_at(0, SIG_MEMREAD, 8'd1, "post_ill_memread");
      expect_at(0, SIG_ALUSRCB, 8'd1, "post_ill_srcb");
      run_instr("post_ill", 6'b000100, 0, 0, 1'b0, 3, 1'b1);

      // reset asserted during a stalled MEMWR
      OpCode = 6'b101011;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         MemReady = (c < 3);
         #1;
         if (c < 3) @(posedge Clk);
      end
      chk("rstmid_memwrite_before", 32'(MemWrite), 32'd1);
      Rst_n = 1'b0;
      #1;
      chk("rstmid_memwrite", 32'(MemWrite), 32'd0);
      chk("rstmid_done", 32'(InstrDone), 32'd0);
      chk("rstmid_count", 32'(InstrCount), 32'd0);
      exp_cnt = 0;
      @(negedge Clk);
      #1;
      chk("rstmid_iord", 32'(IorD), 32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      #1;
      chk("rstmid_fetch_memread", 32'(MemRead), 32'd1);
      chk("rstmid_fetch_irwrite", 32'(IRWrite), 32'd0);
      chk("rstmid_fetch_memwrite", 32'(MemWrite), 32'd0);
      chk("rstmid_count_after", 32'(InstrCount), 32'd0);

      // normal operation resumes from FETCH
      expect_at(0, SIG_MEMREAD, 8'd1, "resume_memread");
      expect_at(3, SIG_REGDST, 8'd1, "resume_regdst");
      run_instr("resume", 6'b000000, 0, 0, 1'b0, 4, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
